// File: rtl/hmem_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// torrence_types : shared FSM / operation encodings for hmem_responder   rev 1.0
// ----------------------------------------------------------------------------
package torrence_types;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LATENCY     = 2'd1,
    READ_BURST  = 2'd2,
    WRITE_BURST = 2'd3
  } hmem_state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } hmem_op_e;

  // Width helper that never returns zero, so single-entry counters stay legal.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hmem_responder_storage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hmem_storage : backing word array, one sync write port, one comb read port rev 1.0
// ----------------------------------------------------------------------------
module hmem_storage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // No reset: contents must survive a reset that aborts a burst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/hmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hmem_responder : line fill / writeback memory responder; optional HMEM_ADDR_CHECK_EN
// rev 1.0
// ----------------------------------------------------------------------------
module hmem_responder
  import torrence_types::*;
#(
  parameter int LINE_SIZE    = 32,
  parameter int XLEN         = 32,
  parameter int MEM_SIZE     = 4096,
  parameter int READ_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_if,
  input  logic            hmem_req_valid,
  output logic            hmem_req_ready,
  input  logic            hmem_rw,
  input  logic [XLEN-1:0] hmem_block_address,
  output logic [XLEN-1:0] hmem_rdata,
  output logic            hmem_rdata_valid,
  input  logic [XLEN-1:0] hmem_wdata,
  output logic            hmem_wdata_ready,
  output logic            hmem_done,
  output logic            hmem_error
);

  localparam int WORDS     = LINE_SIZE * 8 / XLEN;
  localparam int MEM_WORDS = MEM_SIZE * 8 / XLEN;
  localparam int LINES     = MEM_SIZE / LINE_SIZE;
  localparam int OFF_W     = clog2_min1(WORDS);
  localparam int LINE_W    = clog2_min1(LINES);
  localparam int AW        = LINE_W + OFF_W;
  localparam int LINE_LSB  = $clog2(LINE_SIZE);
  localparam int ADDR_W    = $clog2(MEM_SIZE);
  localparam int LAT_W     = clog2_min1(READ_LATENCY);

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;

  hmem_state_e       state, state_next;
  logic [LINE_W-1:0] line;
  logic [OFF_W-1:0]  offset;
  logic [LAT_W-1:0]  lat_cnt;
  logic              addr_err;
  logic              req_err;
  logic              accept;
  logic              last_word;
  logic              mem_we;
  logic [XLEN-1:0]   mem_rdata;
  logic              unused_addr_bits;

  assign hmem_req_ready = (state == IDLE) && !rst_if;
  assign accept         = hmem_req_valid && hmem_req_ready;
  assign last_word      = (offset == '0);
  assign unused_addr_bits = ^{hmem_block_address[XLEN-1:ADDR_W], hmem_block_address[LINE_LSB-1:0]};

`ifdef HMEM_ADDR_CHECK_EN
  assign req_err    = (hmem_block_address >= XLEN'(MEM_SIZE));
  assign hmem_error = hmem_done && addr_err;
`else
  assign req_err    = 1'b0;
  assign hmem_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_if) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    hmem_rdata_valid = 1'b0;
    hmem_wdata_ready = 1'b0;
    hmem_done        = 1'b0;
    hmem_rdata       = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (hmem_op_e'(hmem_rw) == WRITE) begin
            state_next = WRITE_BURST;
          end else if (READ_LATENCY == 0) begin
            state_next = READ_BURST;
          end else begin
            state_next = LATENCY;
          end
        end
      end
      LATENCY: begin
        if (lat_cnt == '0) begin
          state_next = READ_BURST;
        end
      end
      READ_BURST: begin
        hmem_rdata_valid = 1'b1;
        hmem_done        = last_word;
        hmem_rdata       = addr_err ? '0 : mem_rdata;
        if (last_word) begin
          state_next = IDLE;
        end
      end
      WRITE_BURST: begin
        hmem_wdata_ready = 1'b1;
        hmem_done        = last_word;
        if (last_word) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Offset counts down so the first beat carries the highest word of the line.
  always_ff @(posedge clk) begin
    if (rst_if) begin
      line     <= '0;
      offset   <= '0;
      lat_cnt  <= '0;
      addr_err <= 1'b0;
    end else if (accept) begin
      line     <= hmem_block_address[ADDR_W-1:LINE_LSB];
      offset   <= LAST_OFF;
      lat_cnt  <= LAT_INIT;
      addr_err <= req_err;
    end else begin
      if ((state == LATENCY) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (((state == READ_BURST) || (state == WRITE_BURST)) && !last_word) begin
        offset <= offset - 1'b1;
      end
    end
  end

  assign mem_we = hmem_wdata_ready && !addr_err;

  hmem_storage #(
    .XLEN  (XLEN),
    .DEPTH (MEM_WORDS),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (mem_we),
    .waddr ({line, offset}),
    .wdata (hmem_wdata),
    .raddr ({line, offset}),
    .rdata (mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_hmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hmem_responder : randomized bench for hmem_responder (latency 4 and 0)  rev 1.0
// ----------------------------------------------------------------------------
module tb_hmem_responder;

  localparam int LINE_SIZE = 32;
  localparam int MEM_SIZE  = 4096;
  localparam int WORDS     = 8;
  localparam int LINES     = MEM_SIZE / LINE_SIZE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_if, req_valid, rw;
  logic [31:0] addr, wdata;

  logic        rdy_a, rv_a, wr_a, done_a, err_a;
  logic [31:0] rd_a;
  logic        rdy_b, rv_b, wr_b, done_b, err_b;
  logic [31:0] rd_b;

  logic        use_l0;
  logic        cur_rdy, cur_rv, cur_done, cur_err;
  logic [31:0] cur_rd;

  assign cur_rdy  = use_l0 ? rdy_b  : rdy_a;
  assign cur_rv   = use_l0 ? rv_b   : rv_a;
  assign cur_done = use_l0 ? done_b : done_a;
  assign cur_err  = use_l0 ? err_b  : err_a;
  assign cur_rd   = use_l0 ? rd_b   : rd_a;

  hmem_responder #(.READ_LATENCY(4)) dut (
    .clk(clk), .rst_if(rst_if), .hmem_req_valid(req_valid), .hmem_req_ready(rdy_a),
    .hmem_rw(rw), .hmem_block_address(addr), .hmem_rdata(rd_a), .hmem_rdata_valid(rv_a),
    .hmem_wdata(wdata), .hmem_wdata_ready(wr_a), .hmem_done(done_a), .hmem_error(err_a)
  );

  hmem_responder #(.READ_LATENCY(0)) dut_l0 (
    .clk(clk), .rst_if(rst_if), .hmem_req_valid(req_valid), .hmem_req_ready(rdy_b),
    .hmem_rw(rw), .hmem_block_address(addr), .hmem_rdata(rd_b), .hmem_rdata_valid(rv_b),
    .hmem_wdata(wdata), .hmem_wdata_ready(wr_b), .hmem_done(done_b), .hmem_error(err_b)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [LINES*WORDS];
  logic [31:0] send  [WORDS];

  function automatic int line_of(input logic [31:0] a);
    return int'((a / LINE_SIZE) % LINES);
  endfunction

  function automatic bit is_err(input logic [31:0] a);
`ifdef HMEM_ADDR_CHECK_EN
    return a >= MEM_SIZE;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rdy_a && rdy_b) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout got rdy_a=%b rdy_b=%b exp=1", rdy_a, rdy_b);
  endtask

  task automatic do_write(input logic [31:0] a);
    logic [7:0] got, exp;
    bit e;
    e = is_err(a);
    wait_idle();
    req_valid = 1'b1; rw = 1'b1; addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      wdata = send[k];
      @(negedge clk);
      got = {wr_a, done_a, rdy_a, err_a, wr_b, done_b, rdy_b, err_b};
      exp = {1'b1, k == WORDS-1, 1'b0, (k == WORDS-1) && e,
             1'b1, k == WORDS-1, 1'b0, (k == WORDS-1) && e};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL write_hs addr=%h beat=%0d got=%b exp=%b", a, k, got, exp);
      end
      if (!e) model[line_of(a)*WORDS + (WORDS-1-k)] = send[k];
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({wr_a, rdy_a, wr_b, rdy_b} !== 4'b0101) begin
      errors++;
      $display("FAIL write_end addr=%h got=%b exp=0101", a, {wr_a, rdy_a, wr_b, rdy_b});
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int lat);
    logic [35:0] got, exp;
    logic [31:0] ed;
    bit in_burst, e;
    int j;
    e = is_err(a);
    wait_idle();
    use_l0 = (lat == 0);
    req_valid = 1'b1; rw = 1'b0; addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= lat + WORDS + 1; k++) begin
      @(negedge clk);
      in_burst = (k > lat) && (k <= lat + WORDS);
      j = k - lat - 1;
      ed = 32'h0;
      if (in_burst && !e) ed = model[line_of(a)*WORDS + (WORDS-1-j)];
      exp = {in_burst, k == lat + WORDS, k == lat + WORDS + 1, (k == lat + WORDS) && e, ed};
      got = {cur_rv, cur_done, cur_rdy, cur_err, cur_rd};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL read lat=%0d addr=%h cyc=%0d got=%h exp=%h", lat, a, k, got, exp);
      end
    end
  endtask

  task automatic fill_send_random();
    for (int k = 0; k < WORDS; k++) send[k] = $urandom;
  endtask

  task automatic test_reset();
    rst_if = 1'b1; req_valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0; use_l0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy_a, rv_a, wr_a, done_a, err_a, rd_a, rdy_b, rv_b, wr_b, done_b, err_b, rd_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a=%b%b%b%b%b/%h b=%b%b%b%b%b/%h exp=0",
               rdy_a, rv_a, wr_a, done_a, err_a, rd_a, rdy_b, rv_b, wr_b, done_b, err_b, rd_b);
    end
    @(posedge clk); #1;
    rst_if = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy_a, rdy_b} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=11", {rdy_a, rdy_b});
    end
  endtask

  task automatic test_write_read_0x40();
    for (int k = 0; k < WORDS; k++) send[k] = 32'h11 + k;
    do_write(32'h40);
    do_read(32'h40, 4);
    do_read(32'h45, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] written [6];
    for (int i = 0; i < 6; i++) begin
      a = ($urandom_range(0, LINES-1) * LINE_SIZE) | $urandom_range(0, LINE_SIZE-1);
      written[i] = a;
      fill_send_random();
      do_write(a);
      do_read(a, ($urandom_range(0, 1) == 1) ? 4 : 0);
    end
    for (int i = 0; i < 3; i++) do_read(written[$urandom_range(0, 5)], 4);
  endtask

  task automatic test_back_to_back_hold();
    int beats;
    wait_idle();
    use_l0 = 1'b0;
    req_valid = 1'b1; rw = 1'b0; addr = 32'h40;
    @(posedge clk);
    for (int k = 1; k <= 4 + WORDS; k++) begin
      @(negedge clk);
      checks++;
      if (rdy_a !== 1'b0) begin
        errors++;
        $display("FAIL hold_busy cyc=%0d got rdy=%b exp=0", k, rdy_a);
      end
    end
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL hold_ready_return got=%b exp=1", rdy_a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    beats = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rv_a) beats++;
    end
    checks++;
    if (beats !== WORDS) begin
      errors++;
      $display("FAIL hold_second_burst got beats=%0d exp=%0d", beats, WORDS);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a;
    logic [7:0] got;
    a = 32'h300;
    fill_send_random();
    do_write(a);
    fill_send_random();
    wait_idle();
    req_valid = 1'b1; rw = 1'b1; addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wdata = send[k];
      if (k == 2) rst_if = 1'b1;
      @(negedge clk);
      checks++;
      if ({wr_a, done_a, wr_b, done_b} !== 4'b1010) begin
        errors++;
        $display("FAIL rst_write_beat beat=%0d got=%b exp=1010", k, {wr_a, done_a, wr_b, done_b});
      end
      model[line_of(a)*WORDS + (WORDS-1-k)] = send[k];
      @(posedge clk); #1;
    end
    @(negedge clk);
    got = {rdy_a, rv_a, wr_a, done_a, rdy_b, rv_b, wr_b, done_b};
    checks++;
    if (got !== 8'h00 || rd_a !== 32'h0 || rd_b !== 32'h0) begin
      errors++;
      $display("FAIL rst_abort_outputs got=%b rd=%h/%h exp=0", got, rd_a, rd_b);
    end
    @(posedge clk); #1;
    rst_if = 1'b0;
    do_read(a, 4);
  endtask

  task automatic test_out_of_range();
    fill_send_random();
    do_write(32'h0);
    do_read(32'h2000, 4);
    do_read(32'h2000, 0);
    fill_send_random();
    do_write(32'h2040);
    do_read(32'h40, 4);
  endtask

  initial begin
    test_reset();
    test_write_read_0x40();
    test_random();
    test_back_to_back_hold();
    test_reset_mid_write();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
